hls_mul_share_ctrl: RTL and testbench
=====================================

Name: hls_mul_share_ctrl

Overview:
- Controller that time-shares one pipelined signed multiplier among NREQ requesters inside an hlsyn-generated datapath.
- Typical requesters are scheduled states of the synthesized FSM whose multiplies fall in different cycles.
- Round-robin arbitration accepts at most one operation per cycle. The result returns to the granted requester, tagged in-order, exactly LAT cycles after grant.

Parameters:
- NREQ, 3, number of requesters (2..8).
- DW, 8, signed operand width.
- LAT, 2, multiplier pipeline depth in cycles (1..4); grant-to-result latency.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- en  in  1  grant enable; when low, no new grants, in-flight ops drain.
- req  in  NREQ  per-requester request, held until gnt.
- a_in  in  NREQ*DW  packed signed operand A; requester i occupies bits [i*DW +: DW].
- b_in  in  NREQ*DW  packed signed operand B, same packing.
- gnt  out  NREQ  one-hot accept pulse, registered.
- res  out  2*DW  signed product (DW when SAT_OUT_EN).
- res_vld  out  NREQ  one-hot result-valid pulse for the owning requester.
- busy  out  1  high while any op is in flight.

Behaviour:
- Reset (rst==0 at a clk edge):
  - gnt=0, res_vld=0, res=0, busy=0.
  - Round-robin pointer = 0.
  - All pipeline valid/tag bits are cleared. Ops in flight are discarded; no res_vld is ever issued for them.
- Arbitration, evaluated each cycle with en==1:
  - Search req starting at the pointer, wrapping modulo NREQ. The first asserted index i wins.
  - gnt[i] asserts at the next edge for exactly 1 cycle.
  - Operands a_in/b_in of requester i are captured on the same edge into pipeline stage 0.
  - Pointer becomes (i+1) mod NREQ.
  - No req asserted: no grant, pointer unchanged.
- en==0: no grant, pointer frozen, pipeline keeps advancing.
- Requester protocol:
  - Requester holds req and operands stable until it sees gnt.
  - Deasserting req without a grant (withdraw) is legal and has no side effects.
  - req still high in the cycle gnt is visible is treated as a new request (back-to-back ops by one requester allowed). Round-robin still gives other waiting requesters priority.
- Pipeline:
  - LAT stages, each holding {valid, tag[$clog2(NREQ)], partial/product}.
  - Multiply is full signed: sign-extend both operands to 2*DW; the product always fits, no overflow.
  - An op captured with gnt at edge t drives res and res_vld[tag] at edge t+LAT for exactly 1 cycle.
  - res holds its last value when res_vld==0.
  - No backpressure: the requester must consume res in the res_vld cycle.
- Throughput: one op per cycle. Results return in grant order.
- busy = OR of all stage valid bits, or any gnt currently asserted.
- Simultaneous events:
  - A result for requester i can coincide with a new gnt to i; both are asserted.
  - All NREQ requesting continuously: grants cycle 0,1,2,0,... with no starvation. Worst-case wait is NREQ-1 cycles.

Optional Feature:
- Macro: HLS_MUL_SAT_OUT_EN.
- Defined:
  - res is DW wide.
  - Product saturates to [-2^(DW-1), 2^(DW-1)-1]; e.g. DW=8 clamps to -128/127.
  - Saturation happens in the final stage; latency unchanged.
- Undefined: res is 2*DW wide, full product, no saturation logic.

Decomposition:
- Package hls_mul_pkg holds:
  - DW/LAT defaults.
  - Function tag width clog2.
  - Typedef for a pipeline-stage struct {vld, tag, data}.
  - Saturation limit constants.
- Sub-module hls_rr_arb:
  - Parameter NREQ; inputs req, en; outputs one-hot grant and index.
  - Owns the pointer; is reset by the same rst.
- Top level instantiates hls_rr_arb plus the LAT-stage multiply pipeline.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=3'b111 -> gnt=0, res_vld=0, res=0, busy=0. First grant after release goes to requester 0.
- Single op: req=3'b010, a1=-7, b1=12, LAT=2 -> gnt=3'b010 next edge. Two edges later res=-84 and res_vld=3'b010 for 1 cycle; busy drops after.
- Fairness: req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100. res_vld follows the same order offset by LAT.
- en gating / drain: grant an op, then en=0 with req=3'b101 -> no further gnt. The in-flight result still arrives at t+LAT; pointer unchanged when en returns.
- Reset mid-flight: grant a=127, b=127, assert rst=0 one cycle later -> no res_vld ever appears for that op; all outputs read 0.
- Saturation (HLS_MUL_SAT_OUT_EN): a=-128, b=-128 -> res=127. a=100, b=-3 -> res=-128. a=5, b=-6 -> res=-30.

Source files
------------

// File: rtl/hls_mul_pkg.sv
// Shared definitions for the time-shared multiplier controller.
//   - Default configuration (NREQ/DW/LAT).
//   - tag_w(): width of a requester tag (clog2, minimum 1).
//   - mul_stage_t: pipeline-stage layout {vld, tag, data} at the default widths.
//   - sat_hi()/sat_lo(): saturation limits for a DW-bit signed result
//     (used when HLS_MUL_SAT_OUT_EN is defined).
package hls_mul_pkg;

  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned LAT_DEF  = 2;
  localparam int unsigned TAG_MAX  = 3;  // enough for up to 8 requesters

  function automatic int unsigned tag_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  typedef struct packed {
    logic                       vld;
    logic [TAG_MAX-1:0]         tag;
    logic signed [2*DW_DEF-1:0] data;
  } mul_stage_t;

  function automatic longint sat_hi(input int unsigned dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/hls_rr_arb.sv
// Round-robin arbiter for the shared multiplier.
//   clk, rst   : clock, synchronous active-low reset
//   en         : arbitration enable; when low no grant and pointer frozen
//   req[NREQ]  : requests
//   grant[NREQ]: combinational one-hot decision for this cycle
//   idx        : index of the winner
//   vld        : a winner exists this cycle
// The pointer advances to winner+1 whenever a grant is issued.
module hls_rr_arb
  import hls_mul_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned TW   = tag_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [TW-1:0]   idx,
  output logic            vld
);

  logic [TW-1:0] ptr;
  int unsigned   j;

  // Scan from the pointer, wrapping modulo NREQ; first asserted request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (en && !vld && req[TW'(j)]) begin
        vld              = 1'b1;
        grant[TW'(j)]    = 1'b1;
        idx              = TW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (vld) begin
      ptr <= (idx == TW'(NREQ - 1)) ? '0 : idx + TW'(1);
    end
  end

endmodule

// File: rtl/hls_mul_share_ctrl.sv
// Controller time-sharing one pipelined signed multiplier among NREQ requesters.
//   clk, rst      : clock, synchronous active-low reset
//   en            : grant enable; in-flight ops keep draining when low
//   req[NREQ]     : per-requester request, held until gnt
//   a_in, b_in    : packed signed operands, requester i at [i*DW +: DW]
//   gnt[NREQ]     : registered one-hot accept pulse
//   res           : signed product, 2*DW wide (DW wide, saturated, when
//                   HLS_MUL_SAT_OUT_EN is defined); holds when no result
//   res_vld[NREQ] : one-hot result pulse for the owning requester
//   busy          : any op in flight or a grant currently asserted
// Result for an op granted at edge t appears at edge t+LAT.
module hls_mul_share_ctrl
  import hls_mul_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned LAT  = LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     a_in,
  input  logic [NREQ*DW-1:0]     b_in,
  output logic [NREQ-1:0]        gnt,
`ifdef HLS_MUL_SAT_OUT_EN
  output logic signed [DW-1:0]   res,
`else
  output logic signed [2*DW-1:0] res,
`endif
  output logic [NREQ-1:0]        res_vld,
  output logic                   busy
);

  localparam int unsigned TW = tag_w(NREQ);
`ifdef HLS_MUL_SAT_OUT_EN
  localparam int unsigned RW = DW;
`else
  localparam int unsigned RW = 2 * DW;
`endif

  typedef struct packed {
    logic                   vld;
    logic [TW-1:0]          tag;
    logic signed [2*DW-1:0] data;
  } stage_t;

  logic [NREQ-1:0]        sel;
  logic [TW-1:0]          sel_idx;
  logic                   sel_vld;
  logic signed [DW-1:0]   a_sel;
  logic signed [DW-1:0]   b_sel;
  logic signed [2*DW-1:0] prod;
  stage_t                 pipe [LAT];
  stage_t                 last;
  logic signed [RW-1:0]   res_next;
  logic                   pipe_busy;

  hls_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .grant (sel),
    .idx   (sel_idx),
    .vld   (sel_vld)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        a_sel = a_in[i*DW +: DW];
        b_sel = b_in[i*DW +: DW];
      end
    end
  end

  assign prod = $signed({{DW{a_sel[DW-1]}}, a_sel}) * $signed({{DW{b_sel[DW-1]}}, b_sel});

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt <= '0;
      for (int unsigned k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      gnt     <= sel;
      pipe[0] <= '{vld: sel_vld, tag: sel_idx, data: prod};
      for (int unsigned k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign last = pipe[LAT-1];

`ifdef HLS_MUL_SAT_OUT_EN
  localparam logic signed [2*DW-1:0] SAT_HI = (2*DW)'(sat_hi(DW));
  localparam logic signed [2*DW-1:0] SAT_LO = (2*DW)'(sat_lo(DW));

  always_comb begin
    res_next = last.data[DW-1:0];
    if (last.data > SAT_HI)      res_next = SAT_HI[DW-1:0];
    else if (last.data < SAT_LO) res_next = SAT_LO[DW-1:0];
  end
`else
  assign res_next = last.data;
`endif

  // Output register is the edge at which the result becomes visible (t+LAT).
  always_ff @(posedge clk) begin
    if (!rst) begin
      res     <= '0;
      res_vld <= '0;
    end else begin
      res_vld <= '0;
      if (last.vld) begin
        res_vld[last.tag] <= 1'b1;
        res               <= res_next;
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned k = 0; k < LAT; k++) pipe_busy = pipe_busy | pipe[k].vld;
  end

  assign busy = pipe_busy | (|gnt);

endmodule

// File: tb/tb_hls_mul_share_ctrl.sv
// Directed self-checking bench for hls_mul_share_ctrl (NREQ=3, DW=8, LAT=2).
// Expected results saturate when HLS_MUL_SAT_OUT_EN is defined.
module tb_hls_mul_share_ctrl;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned LAT  = 2;
`ifdef HLS_MUL_SAT_OUT_EN
  localparam int unsigned RW = DW;
`else
  localparam int unsigned RW = 2 * DW;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req;
  logic signed [DW-1:0] a [NREQ];
  logic signed [DW-1:0] b [NREQ];
  logic [NREQ*DW-1:0]   a_in;
  logic [NREQ*DW-1:0]   b_in;
  logic [NREQ-1:0]      gnt;
  logic [RW-1:0]        res;
  logic [NREQ-1:0]      res_vld;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign a_in = {a[2], a[1], a[0]};
  assign b_in = {b[2], b[1], b[0]};

  hls_mul_share_ctrl #(.NREQ(NREQ), .DW(DW), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .res     (res),
    .res_vld (res_vld),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rexp(input int p);
    int q;
    q = p;
`ifdef HLS_MUL_SAT_OUT_EN
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
`endif
    return RW'(q);
  endfunction

  logic [NREQ-1:0] seq [3];
  int              pv  [3];
  int              r;

  initial begin
    seq = '{3'b001, 3'b010, 3'b100};
    pv  = '{3, 6, 9};
    rst = 1'b0;
    en  = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end

    // Reset held with all requests pending
    repeat (3) tick();
    check("rst_gnt",  64'(gnt),     64'(0));
    check("rst_vld",  64'(res_vld), 64'(0));
    check("rst_res",  64'(res),     64'(0));
    check("rst_busy", 64'(busy),    64'(0));

    // First grant after release goes to requester 0
    rst = 1'b1;
    tick();
    check("first_gnt", 64'(gnt), 64'(3'b001));
    req = 3'b000;
    tick();
    tick();
    check("first_vld", 64'(res_vld), 64'(3'b001));

    // Single op from requester 1: -7 * 12 = -84
    a[1] = -8'sd7; b[1] = 8'sd12; req = 3'b010;
    tick();
    check("single_gnt",  64'(gnt),  64'(3'b010));
    check("single_busy", 64'(busy), 64'(1));
    req = 3'b000;
    tick();
    check("single_vld_early", 64'(res_vld), 64'(0));
    check("single_gnt_pulse", 64'(gnt),     64'(0));
    tick();
    check("single_vld",  64'(res_vld), 64'(3'b010));
    check("single_res",  64'(res),     64'(rexp(-84)));
    check("single_idle", 64'(busy),    64'(0));
    tick();
    check("single_vld_pulse", 64'(res_vld), 64'(0));
    check("single_res_hold",  64'(res),     64'(rexp(-84)));

    // Reset mid-flight: 127*127 must never produce a result
    a[0] = 8'sd127; b[0] = 8'sd127; req = 3'b001;
    tick();
    check("mid_gnt", 64'(gnt), 64'(3'b001));
    rst = 1'b0; req = 3'b000;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("mid_no_vld", 64'(res_vld), 64'(0));
      tick();
    end
    check("mid_res",  64'(res),  64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_gnt0", 64'(gnt),  64'(0));

    // Fairness: all three requesting for 6 cycles, pointer restarted at 0
    a[0] = 8'sd1; a[1] = 8'sd2; a[2] = 8'sd3;
    b[0] = 8'sd3; b[1] = 8'sd3; b[2] = 8'sd3;
    req = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) req = 3'b000;
      check("fair_gnt", 64'(gnt), (k <= 6) ? 64'(seq[(k-1)%3]) : 64'(0));
      if (k >= 3) begin
        r = (k - 3) % 3;
        check("fair_vld", 64'(res_vld), 64'(seq[r]));
        check("fair_res", 64'(res),     64'(rexp(pv[r])));
      end else begin
        check("fair_vld0", 64'(res_vld), 64'(0));
      end
    end

    // en gating: in-flight op drains, no new grants, pointer frozen at 1
    a[0] = -8'sd2; b[0] = 8'sd50; req = 3'b001;
    tick();
    check("en_gnt", 64'(gnt), 64'(3'b001));
    a[2] = -8'sd128; b[2] = -8'sd128;
    en = 1'b0; req = 3'b101;
    tick();
    check("en_nogrant1", 64'(gnt), 64'(0));
    tick();
    check("en_nogrant2", 64'(gnt),     64'(0));
    check("en_drain_vld", 64'(res_vld), 64'(3'b001));
    check("en_drain_res", 64'(res),     64'(rexp(-100)));
    tick();
    check("en_nogrant3", 64'(gnt),  64'(0));
    check("en_idle",     64'(busy), 64'(0));
    en = 1'b1;
    tick();
    check("en_ptr_kept", 64'(gnt), 64'(3'b100));
    req = 3'b000;
    tick();
    tick();
    check("neg_neg_vld", 64'(res_vld), 64'(3'b100));
    check("neg_neg_res", 64'(res),     64'(rexp(16384)));

    // Back-to-back ops from requester 0; result coincides with a new grant
    a[0] = -8'sd128; b[0] = 8'sd127; req = 3'b001;
    tick();
    check("b2b_gnt1", 64'(gnt), 64'(3'b001));
    a[0] = 8'sd100; b[0] = -8'sd3;
    tick();
    check("b2b_gnt2", 64'(gnt), 64'(3'b001));
    a[0] = 8'sd5; b[0] = -8'sd6;
    tick();
    check("b2b_gnt3",  64'(gnt),     64'(3'b001));
    check("b2b_vld1",  64'(res_vld), 64'(3'b001));
    check("b2b_res1",  64'(res),     64'(rexp(-16256)));
    req = 3'b000;
    tick();
    check("b2b_res2", 64'(res), 64'(rexp(-300)));
    tick();
    check("b2b_res3", 64'(res),     64'(rexp(-30)));
    check("b2b_vld3", 64'(res_vld), 64'(3'b001));
    tick();
    check("b2b_end_vld",  64'(res_vld), 64'(0));
    check("b2b_end_busy", 64'(busy),    64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
